// File: rtl/hbc_bist_if.sv
// hbc_bist_if: request/data handshake between the BIST master and the hbc controller
interface hbc_bist_if #(
  parameter int AW = 21,
  parameter int DW = 16
);
  logic          start;
  logic          rdwr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wdata_next;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          busy;
  modport master (output start, rdwr, addr, wdata, input wdata_next, rdata_ready, rdata, busy);
  modport slave  (input start, rdwr, addr, wdata, output wdata_next, rdata_ready, rdata, busy);
endinterface

// File: rtl/hbc_bist.sv
// hbc_bist: writes NBURSTS bursts of patterned data through hbc, reads them back and checks them
module hbc_bist #(
  parameter int            AW      = 21,
  parameter int            DW      = 16,
  parameter int            BURST   = 4,
  parameter int            NBURSTS = 4,
  parameter logic [AW-1:0] BASE    = 'h4,
  parameter logic [AW-1:0] STRIDE  = 'h100,
  parameter logic [15:0]   SEED    = 16'hAA55,
  parameter logic [15:0]   INC     = 16'h0101,
  parameter int            TMO     = 1024,
  parameter int            ERRW    = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            run,
  input  logic [1:0]      mode,
  output logic            active,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [ERRW-1:0] err_cnt,
  output logic [AW-1:0]   first_err_addr,
  output logic [DW-1:0]   first_err_data,
  hbc_bist_if.master      hbc
);
  localparam int GW = DW > 16 ? DW : 16;
  localparam int KW = NBURSTS > 1 ? $clog2(NBURSTS) : 1;
  localparam int IW = $clog2(BURST + 1);
  localparam int WW = TMO > 1 ? $clog2(TMO) : 1;
  localparam logic [KW-1:0] KL = KW'(NBURSTS - 1);
  localparam logic [IW-1:0] BL = IW'(BURST);
  localparam logic [WW-1:0] WL = WW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, W_REQ, W_BSY, W_END, R_REQ, R_BSY, R_END, DONE} state_t;
  state_t state, nxt;

  logic [1:0]    mode_q;
  logic [KW-1:0] k;
  logic [IW-1:0] i, i_nxt;
  logic [AW-1:0] baddr;
  logic [GW-1:0] gen, gbase;
  logic [WW-1:0] wd;
  logic          busy_seen, extra, latched;
  logic          is_req, is_bsy, is_end, wr_ph, rd_ph, fall, last, go, take, mis, ext, shrt;
  logic [1:0]    inc;
  logic [ERRW:0] sum;
  logic [DW-1:0] word;

  // Generator state one word later; mode 2 keeps a one-hot rotating inside DW bits
  function automatic logic [GW-1:0] step(input logic [GW-1:0] g, input logic [1:0] m);
    return m == 2'd0 ? g + GW'(INC) :
           m == 2'd1 ? GW'({g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]}) :
           m == 2'd2 ? GW'({g[DW-2:0], g[DW-1]}) : g;
  endfunction

  // Jump a whole burst ahead so short or long bursts cannot skew later words
  function automatic logic [GW-1:0] stepn(input logic [GW-1:0] g, input logic [1:0] m);
    logic [GW-1:0] r;
    r = g;
    for (int n = 0; n < BURST; n++) r = step(r, m);
    return r;
  endfunction

  function automatic logic [GW-1:0] seed_of(input logic [1:0] m);
    return m == 2'd2 ? GW'(1) : GW'(SEED);
  endfunction

  assign is_req = state == W_REQ || state == R_REQ;
  assign is_bsy = state == W_BSY || state == R_BSY;
  assign is_end = state == W_END || state == R_END;
  assign wr_ph  = state == W_REQ || state == W_BSY;
  assign rd_ph  = state == R_REQ || state == R_BSY;
  assign fall   = busy_seen & ~hbc.busy;
  assign last   = k == KL;
  assign go     = (state == IDLE || state == DONE) && run;
  assign word   = mode_q == 2'd3 ? DW'(baddr + AW'(i)) : gen[DW-1:0];
  assign take   = ((wr_ph & hbc.wdata_next) | (rd_ph & hbc.rdata_ready)) & (i < BL);
  assign i_nxt  = i + IW'(take);
  assign mis    = rd_ph & hbc.rdata_ready & (i < BL) & (hbc.rdata != word);
  assign ext    = rd_ph & hbc.rdata_ready & (i == BL) & ~extra;
  assign shrt   = state == R_BSY && fall && i_nxt < BL;
  assign inc    = {1'b0, mis} + {1'b0, ext} + {1'b0, shrt};
  assign sum    = {1'b0, err_cnt} + (ERRW+1)'(inc);

  // State register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;

  // Sequencing through write bursts, read bursts, and the watchdog exit
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: nxt = run ? W_REQ : state;
      W_REQ:      nxt = W_BSY;
      W_BSY:      nxt = fall ? W_END : wd == WL ? DONE : W_BSY;
      W_END:      nxt = last ? R_REQ : W_REQ;
      R_REQ:      nxt = R_BSY;
      R_BSY:      nxt = fall ? R_END : wd == WL ? DONE : R_BSY;
      R_END:      nxt = last ? DONE : R_REQ;
      default:    nxt = IDLE;
    endcase
  end

  // Status and hbc request outputs decoded from the state
  always_comb begin
    active    = state != IDLE && state != DONE;
    done      = state == DONE;
    pass      = done && err_cnt == '0 && !timeout;
    hbc.start = is_req;
    hbc.rdwr  = state == R_REQ || state == R_BSY || state == R_END;
    hbc.addr  = is_req ? baddr : '0;
    hbc.wdata = state == W_REQ || state == W_BSY || state == W_END ? word : '0;
  end

  // Burst/word counters, pattern generator, watchdog and error bookkeeping
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      mode_q <= '0; k <= '0; i <= '0; baddr <= '0; gen <= '0; gbase <= '0; wd <= '0;
      busy_seen <= 1'b0; extra <= 1'b0; latched <= 1'b0; timeout <= 1'b0;
      err_cnt <= '0; first_err_addr <= '0; first_err_data <= '0;
    end else if (go) begin
      mode_q <= mode; k <= '0; i <= '0; baddr <= BASE; gen <= seed_of(mode); gbase <= seed_of(mode);
      wd <= '0; busy_seen <= 1'b0; extra <= 1'b0; latched <= 1'b0; timeout <= 1'b0;
      err_cnt <= '0; first_err_addr <= '0; first_err_data <= '0;
    end else begin
      busy_seen <= is_req ? 1'b0 : busy_seen | (is_bsy & hbc.busy);
      wd <= is_bsy ? wd + WW'(1) : '0;
      if (is_bsy && !fall && wd == WL) timeout <= 1'b1;
      if (is_end) begin
        i     <= '0;
        k     <= last ? '0 : k + KW'(1);
        baddr <= last ? BASE : baddr + STRIDE;
        gen   <= last ? seed_of(mode_q) : stepn(gbase, mode_q);
        gbase <= last ? seed_of(mode_q) : stepn(gbase, mode_q);
      end else if (take) begin
        i   <= i_nxt;
        gen <= step(gen, mode_q);
      end
      extra   <= is_req ? 1'b0 : extra | ext;
      err_cnt <= sum[ERRW] ? '1 : sum[ERRW-1:0];
      if (mis && !latched) begin
        latched        <= 1'b1;
        first_err_addr <= baddr + AW'(i);
        first_err_data <= hbc.rdata;
      end
    end
endmodule

// File: tb/tb_hbc_bist.sv
// tb_hbc_bist: directed scenarios for hbc_bist against a behavioural hbc stub with a word memory
module tb_hbc_bist;
  logic        clk = 1'b0, rstn = 1'b0, run = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        active, done, pass, timeout;
  logic [15:0] err_cnt, first_err_data;
  logic [20:0] first_err_addr;
  logic [15:0] mem [int];
  bit          stub_on = 1'b1, corrupt_en = 1'b0;
  int          rd_words_b0 = 4;
  int          nvec = 0, nerr = 0, nstart = 0;

  hbc_bist_if #(.AW(21), .DW(16)) bus ();

  hbc_bist #(.TMO(16)) dut (
    .clk(clk), .rstn(rstn), .run(run), .mode(mode), .active(active), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .hbc(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.start === 1'b1) nstart <= nstart + 1;

  // hbc stub: busy from the request, one word per cycle, busy falls with the last read word
  initial begin
    int a, n;
    logic rw;
    bus.busy = 1'b0; bus.wdata_next = 1'b0; bus.rdata_ready = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.start === 1'b1 && stub_on) begin
        a = int'(bus.addr); rw = bus.rdwr;
        n = (rw && a == 4) ? rd_words_b0 : 4;
        if (rw && corrupt_en) mem[32'h205] = 16'h0000;
        bus.busy = 1'b1;
        for (int w = 0; w < n; w++) begin
          @(negedge clk);
          if (!rw) begin
            mem[a+w] = bus.wdata; bus.wdata_next = 1'b1;
          end else begin
            bus.rdata = mem.exists(a+w) ? mem[a+w] : 16'h0000; bus.rdata_ready = 1'b1;
            if (w == n - 1) bus.busy = 1'b0;
          end
        end
        @(negedge clk);
        bus.wdata_next = 1'b0; bus.rdata_ready = 1'b0; bus.busy = 1'b0;
      end
    end
  end

  task automatic pulse_run(input logic [1:0] m);
    @(negedge clk); mode = m; run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int c = 0; c < lim && done !== 1'b1; c++) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++; if ({active, done, pass, timeout} !== 4'b0) begin nerr++; $display("FAIL reset_status got %b want 0000", {active, done, pass, timeout}); end
    nvec++; if (err_cnt !== 16'h0) begin nerr++; $display("FAIL reset_err_cnt got %h want 0000", err_cnt); end
    nvec++; if ({first_err_addr, first_err_data} !== 37'h0) begin nerr++; $display("FAIL reset_first_err got %h/%h want 0/0", first_err_addr, first_err_data); end
    nvec++; if ({bus.start, bus.rdwr, bus.addr, bus.wdata} !== 39'h0) begin nerr++; $display("FAIL reset_hbc got %b %b %h %h want zeros", bus.start, bus.rdwr, bus.addr, bus.wdata); end
    rstn = 1'b1;
  endtask

  task automatic test_mode0;
    int base;
    mem.delete(); base = nstart;
    pulse_run(2'd0); mode = 2'd3;
    wait_done(600);
    nvec++; if ({done, pass, timeout} !== 3'b110) begin nerr++; $display("FAIL m0_status got %b want 110", {done, pass, timeout}); end
    nvec++; if (err_cnt !== 16'h0) begin nerr++; $display("FAIL m0_err_cnt got %h want 0000", err_cnt); end
    nvec++; if ({mem[4], mem[5], mem[6], mem[7]} !== 64'hAA55_AB56_AC57_AD58) begin nerr++; $display("FAIL m0_mem4_7 got %h %h %h %h want AA55 AB56 AC57 AD58", mem[4], mem[5], mem[6], mem[7]); end
    nvec++; if (mem[32'h104] !== 16'hAE59) begin nerr++; $display("FAIL m0_mem104 got %h want AE59", mem[32'h104]); end
    nvec++; if (mem[32'h307] !== 16'hB964) begin nerr++; $display("FAIL m0_mem307 got %h want B964", mem[32'h307]); end
    nvec++; if (nstart - base !== 8) begin nerr++; $display("FAIL m0_requests got %0d want 8", nstart - base); end
  endtask

  task automatic test_corrupt;
    corrupt_en = 1'b1;
    pulse_run(2'd0);
    wait_done(600);
    corrupt_en = 1'b0;
    nvec++; if ({done, pass} !== 2'b10) begin nerr++; $display("FAIL cor_status got %b want 10", {done, pass}); end
    nvec++; if (err_cnt !== 16'h1) begin nerr++; $display("FAIL cor_err_cnt got %h want 0001", err_cnt); end
    nvec++; if (first_err_addr !== 21'h205) begin nerr++; $display("FAIL cor_addr got %h want 205", first_err_addr); end
    nvec++; if (first_err_data !== 16'h0000) begin nerr++; $display("FAIL cor_data got %h want 0000", first_err_data); end
  endtask

  task automatic test_back_to_back;
    mem.delete();
    pulse_run(2'd1); wait_done(600);
    nvec++; if ({done, pass, err_cnt} !== 18'h30000) begin nerr++; $display("FAIL lfsr_status got %b %b %h want 1 1 0000", done, pass, err_cnt); end
    nvec++; if ({mem[4], mem[5], mem[6]} !== 48'hAA55_54AA_A954) begin nerr++; $display("FAIL lfsr_mem got %h %h %h want AA55 54AA A954", mem[4], mem[5], mem[6]); end
    pulse_run(2'd2); wait_done(600);
    nvec++; if ({done, pass} !== 2'b11) begin nerr++; $display("FAIL walk_status got %b want 11", {done, pass}); end
    nvec++; if ({mem[4], mem[5], mem[32'h104], mem[32'h307]} !== 64'h0001_0002_0010_8000) begin nerr++; $display("FAIL walk_mem got %h %h %h %h want 0001 0002 0010 8000", mem[4], mem[5], mem[32'h104], mem[32'h307]); end
    pulse_run(2'd3); wait_done(600);
    nvec++; if ({done, pass} !== 2'b11) begin nerr++; $display("FAIL addr_status got %b want 11", {done, pass}); end
    nvec++; if ({mem[32'h104], mem[32'h307]} !== 32'h0104_0307) begin nerr++; $display("FAIL addr_mem got %h %h want 0104 0307", mem[32'h104], mem[32'h307]); end
  endtask

  task automatic test_timeout;
    int base, c;
    stub_on = 1'b0; base = nstart;
    pulse_run(2'd0);
    c = 0;
    while (done !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    stub_on = 1'b1;
    nvec++; if (c > 19) begin nerr++; $display("FAIL tmo_latency got %0d cycles want <=19", c); end
    nvec++; if ({done, timeout, pass, active} !== 4'b1100) begin nerr++; $display("FAIL tmo_status got %b want 1100", {done, timeout, pass, active}); end
    nvec++; if (nstart - base !== 1) begin nerr++; $display("FAIL tmo_requests got %0d want 1", nstart - base); end
  endtask

  task automatic test_reset_mid;
    int c, base;
    pulse_run(2'd0);
    c = 0;
    while (!(bus.start === 1'b1 && bus.rdwr === 1'b1 && bus.addr === 21'h204) && c < 300) begin @(negedge clk); c++; end
    nvec++; if (c >= 300) begin nerr++; $display("FAIL rst_reach_rd2 got %0d cycles want <300", c); end
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    nvec++; if ({active, done, pass, timeout, err_cnt} !== 20'h0) begin nerr++; $display("FAIL rst_async_status got %b %h want 0", {active, done, pass, timeout}, err_cnt); end
    nvec++; if ({bus.start, bus.rdwr, bus.addr, bus.wdata} !== 39'h0) begin nerr++; $display("FAIL rst_async_hbc got %b %b %h %h want zeros", bus.start, bus.rdwr, bus.addr, bus.wdata); end
    repeat (3) @(negedge clk);
    base = nstart; rstn = 1'b1;
    repeat (15) @(negedge clk);
    nvec++; if (nstart - base !== 0 || active !== 1'b0) begin nerr++; $display("FAIL rst_idle got %0d requests active=%b want 0/0", nstart - base, active); end
    pulse_run(2'd0); wait_done(600);
    nvec++; if ({done, pass, timeout} !== 3'b110) begin nerr++; $display("FAIL rst_rerun got %b want 110", {done, pass, timeout}); end
  endtask

  task automatic test_extra_word;
    int base;
    rd_words_b0 = 5; base = nstart;
    pulse_run(2'd0);
    repeat (10) @(negedge clk);
    pulse_run(2'd2);
    wait_done(600);
    rd_words_b0 = 4;
    nvec++; if ({done, pass} !== 2'b10) begin nerr++; $display("FAIL ext_status got %b want 10", {done, pass}); end
    nvec++; if (err_cnt !== 16'h1) begin nerr++; $display("FAIL ext_err_cnt got %h want 0001", err_cnt); end
    nvec++; if (nstart - base !== 8) begin nerr++; $display("FAIL ext_requests got %0d want 8", nstart - base); end
    nvec++; if (mem[32'h104] !== 16'hAE59) begin nerr++; $display("FAIL ext_mode_kept got %h want AE59", mem[32'h104]); end
  endtask

  task automatic test_short_burst;
    rd_words_b0 = 3;
    pulse_run(2'd0);
    wait_done(600);
    rd_words_b0 = 4;
    nvec++; if ({done, pass, timeout} !== 3'b100) begin nerr++; $display("FAIL short_status got %b want 100", {done, pass, timeout}); end
    nvec++; if (err_cnt !== 16'h1) begin nerr++; $display("FAIL short_err_cnt got %h want 0001", err_cnt); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_corrupt;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_extra_word;
    test_short_burst;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1);
  end
endmodule
